imem_responder: RTL

- Instruction-memory responder: the memory end of the imem req/ack/rdata interface driven by the fetch stage.
- Holds a MEM_DEPTH x DATA_WIDTH instruction array that is loaded through a side port by the testbench or boot logic.
- Accepts a fetch request, then returns imem_rdata with a one-cycle imem_ack pulse after a fixed, configurable latency.
- Tolerates a requester that holds req permanently high.

---
 rtl/imem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency req/ack fetch port
// over a side-loaded word array with write-first bypass.
package sp_pkg;
  parameter int ADDR_WIDTH = 32;
  parameter int DATA_WIDTH = 32;
endpackage

module imem_responder #(
  parameter int ADDR_WIDTH   = sp_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = sp_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH    = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  imem_req_i,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  output logic                  imem_ack_o,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  output logic                  imem_err_o,
  input  logic                  load_en_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    enter_resp;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [IDX_W-1:0]        rd_idx;
  logic                    rd_oob;
  logic [IDX_W-1:0]        ld_idx;
  logic                    ld_oob;
  logic                    ld_hit;

  assign ld_idx = load_addr_i[IDX_W-1:0];
  assign ld_oob = {1'b0, load_addr_i} >= DEPTH_W;
  assign rd_idx = rd_addr[IDX_W-1:0];
  assign rd_oob = {1'b0, rd_addr} >= DEPTH_W;
  assign ld_hit = load_en_i && !ld_oob && (ld_idx == rd_idx);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    ack_d      = 1'b0;
    rdata_d    = '0;
    err_d      = 1'b0;
    enter_resp = 1'b0;
    rd_addr    = addr_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (imem_req_i) begin
          addr_d  = imem_addr_i;
          rd_addr = imem_addr_i;
          if (READ_LATENCY == 1) begin
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // A load landing on the read index this edge wins over the array.
    if (enter_resp) begin
      state_d = RESP;
      cnt_d   = '0;
      ack_d   = 1'b1;
      err_d   = rd_oob;
      if (!rd_oob) begin
        rdata_d = ld_hit ? load_data_i : mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_en_i && !ld_oob) begin
      mem[ld_idx] <= load_data_i;
    end
  end

  assign imem_ack_o   = ack_q;
  assign imem_rdata_o = rdata_q;
  assign imem_err_o   = err_q;

endmodule
